// File: rtl/display_update_controller_pkg.sv
// Shared types and constants for the display update sequencer.
// Holds the BCD bus layout, saturation code, FSM states and source encoding.
package display_pkg;
    localparam int BCD_W   = 28;
    localparam int DIGITS  = 4;
    localparam int BCD_PAD = 12;
    localparam int ACC_W   = 20;
    localparam logic [BCD_W-1:0] SAT_CODE = 28'h9999000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    typedef enum logic {
        SRC_ENTRY  = 1'b0,
        SRC_RESULT = 1'b1
    } src_e;
endpackage

// File: rtl/display_update_controller_if.sv
// Handshake and display bus between the binary sources and the display sequencer.
// Sources drive valid/value and hold them until ready; the sequencer drives everything else.
interface display_update_controller_if
    import display_pkg::*;
#(
    parameter int DATA_W = 14
);
    logic              res_valid;
    logic [DATA_W-1:0] res_value;
    logic              res_ready;
    logic              ent_valid;
    logic [DATA_W-1:0] ent_value;
    logic              ent_ready;
    logic [BCD_W-1:0]  BCD_code;
    logic              overflow;
    logic              src_sel;
    logic              busy;
    logic              update_done;

    modport master (
        output res_valid, res_value, ent_valid, ent_value,
        input  res_ready, ent_ready, BCD_code, overflow, src_sel, busy, update_done
    );

    modport slave (
        input  res_valid, res_value, ent_valid, ent_value,
        output res_ready, ent_ready, BCD_code, overflow, src_sel, busy, update_done
    );
endinterface

// File: rtl/display_update_controller_bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more, purely combinational.
// Inputs are always legal BCD (0..9), so the 4-bit sum never wraps.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
endmodule

// File: rtl/display_update_controller.sv
// Arbitrates result/entry sources (result wins), converts to BCD one bit per cycle and commits atomically.
// Latency DATA_W+1 cycles from handshake to BCD_code; both readies stay low until the FSM returns to IDLE.
module display_update_controller
    import display_pkg::*;
#(
    parameter int DATA_W = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    display_update_controller_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    src_e               src_q, src_d;
    logic [BCD_W-1:0]   code_q, code_d;
    logic               overflow_q, overflow_d;
    logic               src_sel_q, src_sel_d;
    logic               done_q, done_d;
    logic               take_res, take_ent;

    for (genvar g = 0; g < ACC_W / 4; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (bcd_q[g*4 +: 4]),
            .digit_o (bcd_adj[g*4 +: 4])
        );
    end

    assign take_res = bus.res_valid && bus.res_ready;
    assign take_ent = bus.ent_valid && bus.ent_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_res || take_ent) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Entry readiness is gated by res_valid so only one value is taken per IDLE cycle.
    always_comb begin
        bus.res_ready = (state_q == IDLE);
        bus.ent_ready = (state_q == IDLE) && !bus.res_valid;
        bus.busy      = (state_q != IDLE);
    end

    always_comb begin
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        code_d     = code_q;
        overflow_d = overflow_q;
        src_sel_d  = src_sel_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_res) begin
                    bin_d = bus.res_value;
                    src_d = SRC_RESULT;
                    bcd_d = '0;
                    cnt_d = '0;
                end else if (take_ent) begin
                    bin_d = bus.ent_value;
                    src_d = SRC_ENTRY;
                    bcd_d = '0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
            end
            COMMIT: begin
                if (bcd_q[ACC_W-1 -: 4] == 4'd0) begin
                    code_d     = {bcd_q[DIGITS*4-1:0], {BCD_PAD{1'b0}}};
                    overflow_d = 1'b0;
                end else begin
                    code_d     = SAT_CODE;
                    overflow_d = 1'b1;
                end
                src_sel_d = src_q;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            src_q      <= SRC_ENTRY;
            code_q     <= '0;
            overflow_q <= 1'b0;
            src_sel_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
            src_sel_q  <= src_sel_d;
            done_q     <= done_d;
        end
    end

    assign bus.BCD_code    = code_q;
    assign bus.overflow    = overflow_q;
    assign bus.src_sel     = src_sel_q;
    assign bus.update_done = done_q;
endmodule

// File: tb/tb_display_update_controller.sv
// Scoreboard bench for display_update_controller: stimulus pushes expected commits,
// a negedge monitor pops and compares them whenever update_done pulses.
module tb_display_update_controller;
    import display_pkg::*;

    localparam int DATA_W = 14;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_update_controller_if #(.DATA_W(DATA_W)) bus ();

    display_update_controller #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [27:0] code;
        logic        ovf;
        logic        src;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Commit monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.update_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: got code %h with nothing expected", bus.BCD_code);
            end else begin
                e = exp_q.pop_front();
                check("commit_code", {4'h0, bus.BCD_code}, {4'h0, e.code});
                check("commit_overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
                check("commit_src_sel", {31'd0, bus.src_sel}, {31'd0, e.src});
            end
        end
    end

    task automatic xfer(input bit is_res, input logic [DATA_W-1:0] v,
                        input logic [27:0] ec, input logic eo, input bit expect_commit);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        if (is_res) begin
            bus.res_valid = 1'b1;
            bus.res_value = v;
        end else begin
            bus.ent_valid = 1'b1;
            bus.ent_value = v;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = is_res ? (bus.res_ready === 1'b1) : (bus.ent_ready === 1'b1);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: ready never seen, expected 1");
        end else if (expect_commit) begin
            exp_q.push_back({ec, eo, is_res});
        end
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        bus.ent_valid = 1'b0;
    endtask

    task automatic wait_busy(input int exp_cycles);
        int n = 0;
        bit done = 1'b0;
        bit rdy_bad = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                n++;
                if (bus.res_ready !== 1'b0 || bus.ent_ready !== 1'b0) rdy_bad = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        check("busy_cycles", n, exp_cycles);
        check("ready_low_while_busy", {31'd0, rdy_bad}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  gap;
        bit  got;
        bus.res_valid = 1'b0;
        bus.res_value = '0;
        bus.ent_valid = 1'b0;
        bus.ent_value = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_code", {4'h0, bus.BCD_code}, 32'h0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_src_sel", {31'd0, bus.src_sel}, 32'd0);
        check("rst_update_done", {31'd0, bus.update_done}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_res_ready", {31'd0, bus.res_ready}, 32'd1);

        // Reset in the middle of converting 1234: nothing may be committed
        xfer(1'b1, 14'd1234, 28'h0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        check("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy_async", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_code", {4'h0, bus.BCD_code}, 32'h0);
        check("abort_overflow", {31'd0, bus.overflow}, 32'd0);

        xfer(1'b1, 14'd1234, 28'h1234000, 1'b0, 1'b1);
        wait_busy(15);

        xfer(1'b1, 14'd12345, 28'h9999000, 1'b1, 1'b1);
        wait_busy(15);
        xfer(1'b0, 14'd42, 28'h0042000, 1'b0, 1'b1);
        wait_busy(15);

        // Simultaneous result and entry: result first, entry in the first IDLE cycle after
        @(posedge clk);
        #1;
        bus.res_valid = 1'b1;
        bus.res_value = 14'd500;
        bus.ent_valid = 1'b1;
        bus.ent_value = 14'd77;
        @(negedge clk);
        check("arb_res_ready", {31'd0, bus.res_ready}, 32'd1);
        check("arb_ent_ready", {31'd0, bus.ent_ready}, 32'd0);
        exp_q.push_back({28'h0500000, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        gap = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            gap++;
            got = (bus.ent_ready === 1'b1);
        end
        check("arb_entry_gap", gap, 16);
        if (got) exp_q.push_back({28'h0077000, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        bus.ent_valid = 1'b0;
        wait_busy(15);

        xfer(1'b1, 14'd0, 28'h0000000, 1'b0, 1'b1);
        wait_busy(15);
        xfer(1'b0, 14'd9999, 28'h9999000, 1'b0, 1'b1);
        wait_busy(15);
        xfer(1'b1, 14'd10000, 28'h9999000, 1'b1, 1'b1);
        wait_busy(15);

        // Inputs churn during conversion; only the handshake value may be committed
        xfer(1'b1, 14'd4321, 28'h4321000, 1'b0, 1'b1);
        fork
            begin
                for (int i = 0; i < 14; i++) begin
                    bus.res_valid = 1'($urandom_range(0, 1));
                    bus.ent_valid = 1'($urandom_range(0, 1));
                    bus.res_value = DATA_W'($urandom);
                    bus.ent_value = DATA_W'($urandom);
                    @(posedge clk);
                    #1;
                end
                bus.res_valid = 1'b0;
                bus.ent_valid = 1'b0;
            end
            wait_busy(15);
        join

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
